// File: rtl/prog_loader.sv
// Program loader: streams an instruction/data image into the CPU
// memories, then enables the CPU until told to stop.
module prog_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = $clog2(IMEM_DEPTH + 1);
  localparam int DW = $clog2(DMEM_DEPTH + 1);
  localparam logic [31:0] IMAX = 32'(IMEM_DEPTH);
  localparam logic [31:0] DMAX = 32'(DMEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    HDR_I,
    HDR_D,
    LOAD_I,
    LOAD_D_LO,
    LOAD_D_HI,
    FLUSH,
    RUN,
    ERR
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   ni_q, ni_d;
  logic [31:0]   nd_q, nd_d;
  logic [IW-1:0] k_q, k_d;
  logic [DW-1:0] j_q, j_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [63:0]   addr2_q, addr2_d;
  logic [63:0]   wdata2_q, wdata2_d;
  logic          wen2_q, wen2_d;
  logic          cpu_q, cpu_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          xfer;
  logic          last_i;
  logic          last_d;

  // Stream is accepted only while collecting header or payload words
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      HDR_I, HDR_D, LOAD_I,
      LOAD_D_LO, LOAD_D_HI: s_ready = 1'b1;
      default:              s_ready = 1'b0;
    endcase
  end

  assign xfer   = s_valid && s_ready;
  assign last_i = (32'(k_q) + 32'd1) == ni_q;
  assign last_d = (32'(j_q) + 32'd1) == nd_q;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d  = state_q;
    ni_d     = ni_q;
    nd_d     = nd_q;
    k_d      = k_q;
    j_d      = j_q;
    lo_d     = lo_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    addr2_d  = addr2_q;
    wdata2_d = wdata2_q;
    wen2_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR_I;
          k_d     = '0;
          j_d     = '0;
        end
      end
      HDR_I: begin
        if (xfer) begin
          ni_d    = s_data;
          state_d = HDR_D;
        end
      end
      HDR_D: begin
        if (xfer) begin
          nd_d = s_data;
          if (ni_q > IMAX || s_data > DMAX)
            state_d = ERR;
          else if (ni_q != 32'd0)
            state_d = LOAD_I;
          else if (s_data != 32'd0)
            state_d = LOAD_D_LO;
          else
            state_d = FLUSH;
        end
      end
      LOAD_I: begin
        if (xfer) begin
          addr_d  = 64'({k_q, 2'b00});
          wdata_d = s_data;
          wen_d   = 1'b1;
          k_d     = k_q + IW'(1);
          if (last_i)
            state_d = (nd_q != 32'd0) ? LOAD_D_LO : FLUSH;
        end
      end
      LOAD_D_LO: begin
        if (xfer) begin
          lo_d    = s_data;
          state_d = LOAD_D_HI;
        end
      end
      LOAD_D_HI: begin
        if (xfer) begin
          addr2_d  = 64'({j_q, 3'b000});
          wdata2_d = {s_data, lo_q};
          wen2_d   = 1'b1;
          j_d      = j_q + DW'(1);
          state_d  = last_d ? FLUSH : LOAD_D_LO;
        end
      end
      FLUSH: state_d = RUN;
      RUN: begin
        if (stop)
          state_d = IDLE;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    busy_d = 1'b0;
    unique case (state_d)
      HDR_I, HDR_D, LOAD_I, LOAD_D_LO,
      LOAD_D_HI, FLUSH: busy_d = 1'b1;
      default:          busy_d = 1'b0;
    endcase
    done_d = (state_d == RUN);
    cpu_d  = (state_d == RUN);
    err_d  = (state_d == ERR);
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      ni_q     <= '0;
      nd_q     <= '0;
      k_q      <= '0;
      j_q      <= '0;
      lo_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      addr2_q  <= '0;
      wdata2_q <= '0;
      wen2_q   <= 1'b0;
      cpu_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ni_q     <= ni_d;
      nd_q     <= nd_d;
      k_q      <= k_d;
      j_q      <= j_d;
      lo_q     <= lo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      addr2_q  <= addr2_d;
      wdata2_q <= wdata2_d;
      wen2_q   <= wen2_d;
      cpu_q    <= cpu_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign addr_ext_2  = addr2_q;
  assign wdata_ext_2 = wdata2_q;
  assign wen_ext_2   = wen2_q;
  assign ren_ext_2   = 1'b0;
  assign cpu_enable  = cpu_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed vector bench for prog_loader: table of cycles plus
// hand-written overflow, backpressure and reset sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start, stop, s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable, busy, done, error;

  int n_chk = 0;
  int n_pass = 0;

  prog_loader dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .stop        (stop),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sp, v;
    logic [31:0] d;
    logic        rdy, wen;
    logic [63:0] addr;
    logic [31:0] wd;
    logic        wen2;
    logic [63:0] addr2, wd2;
    logic        cpu, bsy, dn, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic st, logic sp, logic v, logic [31:0] d,
    logic rdy, logic wen, logic [63:0] addr,
    logic [31:0] wd, logic wen2, logic [63:0] addr2,
    logic [63:0] wd2, logic cpu, logic bsy,
    logic dn, logic err);
    vec_t r;
    r.st = st; r.sp = sp; r.v = v; r.d = d;
    r.rdy = rdy; r.wen = wen; r.addr = addr;
    r.wd = wd; r.wen2 = wen2; r.addr2 = addr2;
    r.wd2 = wd2; r.cpu = cpu; r.bsy = bsy;
    r.dn = dn; r.err = err;
    return r;
  endfunction

  function automatic logic [255:0] pk_exp(vec_t r);
    return 256'({r.rdy, r.wen, r.addr, r.wd, r.wen2,
      r.addr2, r.wd2, r.cpu, r.bsy, r.dn, r.err,
      2'b00});
  endfunction

  function automatic logic [255:0] pk_act();
    return 256'({s_ready, wen_ext, addr_ext, wdata_ext,
      wen_ext_2, addr_ext_2, wdata_ext_2, cpu_enable,
      busy, done, error, ren_ext, ren_ext_2});
  endfunction

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic cyc(logic rn, logic st, logic sp,
                     logic v, logic [31:0] d);
    @(negedge clk);
    arst_n = rn; start = st; stop = sp;
    s_valid = v; s_data = d;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] WD2 = 64'h01234567DEADBEEF;
  localparam logic [31:0] I1  = 32'h00100093;

  logic [31:0] w[8];
  int          idx, pulses;
  logic        acc;

  initial begin
    arst_n = 1'b0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_data = '0;

    // normal load with stall/ignored start, RUN, stop
    tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,2, 1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,1, 1,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,32'h13,
      1,1,0,32'h13,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,32'hFFFF,
      1,0,0,32'h13,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,I1,
      1,1,4,I1,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,32'hDEADBEEF,
      1,0,4,I1,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,1,32'h01234567,
      0,0,4,I1,1,0,WD2, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,4,I1,0,0,WD2, 1,0,1,0));
    tbl.push_back(mk(1,0,1,32'h77,
      0,0,4,I1,0,0,WD2, 1,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,0,4,I1,0,0,WD2, 0,0,0,0));
    tbl.push_back(mk(0,1,1,9, 0,0,4,I1,0,0,WD2, 0,0,0,0));
    // empty image
    tbl.push_back(mk(1,0,0,0, 1,0,4,I1,0,0,WD2, 0,1,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,4,I1,0,0,WD2, 0,1,0,0));
    tbl.push_back(mk(0,0,1,0, 0,0,4,I1,0,0,WD2, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,4,I1,0,0,WD2, 1,0,1,0));
    tbl.push_back(mk(0,1,0,0, 0,0,4,I1,0,0,WD2, 0,0,0,0));

    cyc(0,0,0,0,0);
    cyc(0,0,0,0,0);
    chk("reset", pk_act(), 256'd0);

    foreach (tbl[i]) begin
      cyc(1, tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), pk_act(), pk_exp(tbl[i]));
    end

    // header overflow lands in ERR and sticks until reset
    cyc(1,1,0,0,0);
    cyc(1,0,0,1,513);
    cyc(1,0,0,1,0);
    chk("ovf_err", 256'({error, s_ready, busy, cpu_enable,
      wen_ext, wen_ext_2}), 256'(6'b100000));
    cyc(1,1,0,1,5);
    cyc(1,0,0,1,5);
    chk("ovf_hold", 256'({error, s_ready, busy, cpu_enable,
      wen_ext, wen_ext_2}), 256'(6'b100000));
    cyc(0,0,0,0,0);
    chk("ovf_rst", pk_act(), 256'd0);

    // random backpressure over six instruction words
    w[0] = 6;
    w[1] = 0;
    for (int i = 0; i < 6; i++) w[i+2] = 32'hA000_0000 + i;
    idx = 0;
    pulses = 0;
    for (int c = 0; c < 300 && !cpu_enable; c++) begin
      @(negedge clk);
      arst_n = 1'b1;
      start = (c == 0);
      stop = 1'b0;
      s_valid = (c > 0) && (idx < 8) &&
                ($urandom_range(0, 1) == 1);
      s_data = (idx < 8) ? w[idx] : 32'h0;
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (wen_ext) begin
        chk($sformatf("bp_word%0d", pulses),
          256'({addr_ext, wdata_ext}),
          256'({64'(pulses * 4), 32'hA000_0000 + pulses}));
        pulses++;
      end
      if (wen_ext && wen_ext_2)
        chk("bp_excl", 256'(1), 256'(0));
    end
    chk("bp_end", 256'({32'(pulses), cpu_enable}),
      256'({32'd6, 1'b1}));
    cyc(1,0,1,0,0);

    // reset in the middle of the second dword
    cyc(1,1,0,0,0);
    cyc(1,0,0,1,1);
    cyc(1,0,0,1,2);
    cyc(1,0,0,1,32'h11);
    cyc(1,0,0,1,32'hAAAA);
    cyc(1,0,0,1,32'hBBBB);
    chk("mid_wr0", 256'({wen_ext_2, addr_ext_2, wdata_ext_2}),
      256'({1'b1, 64'd0, 64'h0000BBBB_0000AAAA}));
    cyc(1,0,0,1,32'hCCCC);
    chk("mid_hi", 256'({s_ready, busy, wen_ext_2}),
      256'(3'b110));
    cyc(0,0,0,1,32'hDDDD);
    chk("mid_rst", pk_act(), 256'd0);
    cyc(1,1,0,0,0);
    cyc(1,0,0,1,1);
    cyc(1,0,0,1,0);
    cyc(1,0,0,1,32'h55);
    chk("reload", 256'({wen_ext, addr_ext, wdata_ext}),
      256'({1'b1, 64'd0, 32'h55}));
    cyc(1,0,0,0,0);
    cyc(1,0,0,0,0);
    chk("reload_run", 256'({cpu_enable, done, busy}),
      256'(3'b110));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: IMEM_DEPTH, 512, max instruction words loadable (sizes the instruction-memory address space).
REQ-002 Parameter: DMEM_DEPTH, 1024, max 64-bit data words loadable.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: arst_n  input  1  reset; synchronous, active-low, sampled on the rising edge of clk.
REQ-005 Port: start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 Port: stop  input  1  halts the CPU; honoured only in RUN.
REQ-007 Port: s_valid / s_ready / s_data  input / output / 32-bit input  word stream; transfer when s_valid && s_ready at a clock edge.
REQ-008 Port: addr_ext  output  64  instruction-memory byte address.
REQ-009 Port: wen_ext, ren_ext  output  1 each  instruction-memory write/read enables.
REQ-010 Port: wdata_ext  output  32  instruction word.
REQ-011 Port: addr_ext_2  output  64  data-memory byte address.
REQ-012 Port: wen_ext_2, ren_ext_2  output  1 each  data-memory write/read enables.
REQ-013 Port: wdata_ext_2  output  64  data word.
REQ-014 Port: cpu_enable  output  1  drives the CPU enable input.
REQ-015 Port: busy, done, error  output  1 each  status flags.

Function
REQ-016 Stream format: word0 = N_I (instruction count), word1 = N_D (data-dword count), then N_I instruction words, then N_D dwords, each sent low half first, then high half.
REQ-017 FSM states: IDLE, HDR_I, HDR_D, LOAD_I, LOAD_D_LO, LOAD_D_HI, FLUSH, RUN, ERR.
REQ-018 IDLE: s_ready=0; start=1 -> HDR_I.
REQ-019 HDR_I: s_ready=1; on transfer latch N_I -> HDR_D.
REQ-020 HDR_D: s_ready=1; on transfer latch N_D.
REQ-021 HDR_D exit: ERR if N_I>IMEM_DEPTH or N_D>DMEM_DEPTH; else LOAD_I if N_I>0; else LOAD_D_LO if N_D>0; else FLUSH.
REQ-022 LOAD_I: s_ready=1; k-th transfer (k from 0) registers addr_ext=4*k, wdata_ext=s_data, wen_ext=1 for exactly the next cycle.
REQ-023 LOAD_I exit: after transfer k=N_I-1 -> LOAD_D_LO if N_D>0, else FLUSH.
REQ-024 LOAD_D_LO: s_ready=1; transfer latches the low 32 bits -> LOAD_D_HI; no write issued.
REQ-025 LOAD_D_HI: s_ready=1; j-th transfer registers addr_ext_2=8*j, wdata_ext_2={s_data, low}, wen_ext_2=1 for exactly the next cycle.
REQ-026 LOAD_D_HI exit: after j=N_D-1 -> FLUSH; otherwise -> LOAD_D_LO.
REQ-027 Write pulses are one cycle per word; wen_ext and wen_ext_2 are never high in the same cycle.
REQ-028 Counters: sized to hold IMEM_DEPTH and DMEM_DEPTH; addresses zero-extended to 64 bits; no wrap is possible (REQ-021).
REQ-029 FLUSH: lasts one cycle with no writes -> RUN; this guarantees the last write pulse completes before cpu_enable rises.
REQ-030 RUN: cpu_enable=1; stop=1 -> IDLE with cpu_enable=0 from the next cycle.
REQ-031 ERR: s_ready=0, no writes, error=1, cpu_enable=0; ERR is left only by reset.
REQ-032 busy=1 in HDR_I through FLUSH; done=1 in RUN only.
REQ-033 ren_ext and ren_ext_2 are held 0 at all times.
REQ-034 Ignored inputs: start outside IDLE and stop outside RUN have no effect; s_valid while s_ready=0 is not consumed.
REQ-035 Stalls: s_valid low mid-load holds the state and all counters indefinitely.
REQ-036 All outputs are registered except s_ready, which is decoded from state.

Reset
REQ-037 arst_n=0 at a clock edge -> state IDLE and all counters and latches cleared.
REQ-038 Output values after that edge: all outputs 0 (addresses and data 0, wen_ext=wen_ext_2=0, cpu_enable=0, busy=done=error=0).
REQ-039 A reset in any state, including mid-load or mid-dword, takes effect at that edge; a partially loaded image is abandoned and needs a new start.

Verification
REQ-040 Normal load: stream N_I=2, N_D=1, 0x00000013, 0x00100093, 0xDEADBEEF, 0x01234567 -> wen_ext pulses at addr 0 then 4 with those words; one wen_ext_2 at addr 0 with 0x01234567DEADBEEF; cpu_enable rises 2 cycles after the final accepted word.
REQ-041 Empty image: N_I=0, N_D=0 -> no write pulses; FLUSH then RUN; done=1.
REQ-042 Overflow: N_I=513 -> ERR, error=1, s_ready=0, no writes; reset clears error.
REQ-043 Backpressure: s_valid toggled randomly during LOAD_I -> one pulse per accepted word, addresses contiguous 0,4,8,...
REQ-044 Reset mid-load: arst_n=0 while in LOAD_D_HI -> all outputs 0 next cycle; a fresh start reloads from address 0.
REQ-045 Control: stop in RUN -> cpu_enable=0 next cycle, state IDLE; start during LOAD_I -> ignored, no state change.
